// File: rtl/rv_pkg.sv
// rv_pkg: shared RISC-V widths and register-file constants.
//   XLEN  : default datapath width
//   REG_W : register-address width
//   X0    : index of the hard-wired zero register
//   src_e : writeback source identifier used by the arbiter pointer
package rv_pkg;
    localparam int XLEN = 64;
    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] X0 = '0;
    typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_e;
endpackage

// File: rtl/rv_rf_wb_arb_if.sv
// rv_rf_wb_arb_if: writeback request channels and register-file write port.
//   flush_i                  : discard all pending writes
//   sN_valid/ready/rd/data   : per-source writeback request handshake (N = 0 ALU, 1 load unit)
//   wr_en/wr_reg/wr_data     : register-file write port
//   busy_o                   : per-register pending-write scoreboard
//   master drives requests; slave is the arbiter.
interface rv_rf_wb_arb_if #(parameter int XLEN = rv_pkg::XLEN);
    import rv_pkg::*;
    logic             flush_i;
    logic             s0_valid_i;
    logic             s0_ready_o;
    logic [REG_W-1:0] s0_rd_i;
    logic [XLEN-1:0]  s0_data_i;
    logic             s1_valid_i;
    logic             s1_ready_o;
    logic [REG_W-1:0] s1_rd_i;
    logic [XLEN-1:0]  s1_data_i;
    logic             wr_en_o;
    logic [REG_W-1:0] wr_reg_o;
    logic [XLEN-1:0]  wr_data_o;
    logic [31:0]      busy_o;
    modport master (
        output flush_i, s0_valid_i, s0_rd_i, s0_data_i, s1_valid_i, s1_rd_i, s1_data_i,
        input  s0_ready_o, s1_ready_o, wr_en_o, wr_reg_o, wr_data_o, busy_o
    );
    modport slave (
        input  flush_i, s0_valid_i, s0_rd_i, s0_data_i, s1_valid_i, s1_rd_i, s1_data_i,
        output s0_ready_o, s1_ready_o, wr_en_o, wr_reg_o, wr_data_o, busy_o
    );
endinterface

// File: rtl/rv_rf_wb_slot.sv
// rv_rf_wb_slot: one-entry writeback holding slot with an age bit.
//   clk, rstn            : clock, asynchronous active-low reset
//   flush                : empty the slot at the next edge
//   load, load_rd/data   : capture a new entry
//   load_young           : age of the captured entry (1 = younger than the other slot)
//   age_clr              : other slot's entry is leaving, so this entry becomes the older one
//   clear                : entry granted, empty at the next edge unless reloaded
//   valid, rd, data, young : held entry
module rv_rf_wb_slot #(parameter int XLEN = rv_pkg::XLEN) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     load,
    input  logic                     clear,
    input  logic [rv_pkg::REG_W-1:0] load_rd,
    input  logic [XLEN-1:0]          load_data,
    input  logic                     load_young,
    input  logic                     age_clr,
    output logic                     valid,
    output logic [rv_pkg::REG_W-1:0] rd,
    output logic [XLEN-1:0]          data,
    output logic                     young
);
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid <= 1'b0;
            rd    <= '0;
            data  <= '0;
            young <= 1'b0;
        end else begin
            valid <= !flush && (load || (valid && !clear));
            young <= !flush && (load ? load_young : (young && !age_clr));
            if (load) begin
                rd   <= load_rd;
                data <= load_data;
            end
        end
    end
endmodule

// File: rtl/rv_rf_wb_arb.sv
// rv_rf_wb_arb: two-source register-file writeback arbiter with scoreboard.
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : request channels, register-file write port and busy scoreboard
module rv_rf_wb_arb #(parameter int XLEN = rv_pkg::XLEN) (
    input logic           clk,
    input logic           rstn,
    rv_rf_wb_arb_if.slave bus
);
    import rv_pkg::*;
    logic [1:0]       req_v, rdy, v, yng, ld, gnt, age_in, age_clr;
    logic [REG_W-1:0] req_rd [2];
    logic [REG_W-1:0] rd [2];
    logic [XLEN-1:0]  req_data [2];
    logic [XLEN-1:0]  dat [2];
    logic             sel1;
    src_e             ptr;
    assign req_v       = {bus.s1_valid_i, bus.s0_valid_i};
    assign req_rd[0]   = bus.s0_rd_i;
    assign req_rd[1]   = bus.s1_rd_i;
    assign req_data[0] = bus.s0_data_i;
    assign req_data[1] = bus.s1_data_i;
    // Same destination: the older entry wins; s0 is only younger if it arrived after s1.
    assign sel1 = v[1] && (!v[0] || (rd[0] == rd[1] ? yng[0] : ptr == SRC1));
    assign gnt  = {2{!bus.flush_i}} & {sel1, v[0] && !sel1};
    assign rdy  = {2{!bus.flush_i}} & (~v | gnt);
    assign bus.s0_ready_o = rdy[0];
    assign bus.s1_ready_o = rdy[1];
    // A new entry is younger if the other slot keeps its entry; on simultaneous arrival s1 is younger.
    assign age_in  = {(v[0] && !gnt[0]) || ld[0], v[1] && !gnt[1]};
    assign age_clr = {gnt[0], gnt[1]};
    genvar i;
    for (i = 0; i < 2; i++) begin : g_slot
        assign ld[i] = req_v[i] && rdy[i] && (req_rd[i] != X0);
        rv_rf_wb_slot #(.XLEN(XLEN)) u_slot (
            .clk        (clk),
            .rstn       (rstn),
            .flush      (bus.flush_i),
            .load       (ld[i]),
            .clear      (gnt[i]),
            .load_rd    (req_rd[i]),
            .load_data  (req_data[i]),
            .load_young (age_in[i]),
            .age_clr    (age_clr[i]),
            .valid      (v[i]),
            .rd         (rd[i]),
            .data       (dat[i]),
            .young      (yng[i])
        );
    end
    // The pointer only advances on contended grants; a lone slot is served without consuming a turn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr <= SRC0;
        else if (&v && |gnt) ptr <= gnt[1] ? SRC0 : SRC1;
    end
    assign bus.wr_en_o   = |gnt;
    assign bus.wr_reg_o  = gnt[1] ? rd[1] : gnt[0] ? rd[0] : X0;
    assign bus.wr_data_o = gnt[1] ? dat[1] : gnt[0] ? dat[0] : '0;
    assign bus.busy_o    = ((32'(v[0]) << rd[0]) | (32'(v[1]) << rd[1])) & ~32'd1;
endmodule

// File: tb/tb_rv_rf_wb_arb.sv
// tb_rv_rf_wb_arb: directed vector table, reset sequences and randomized model check for rv_rf_wb_arb.
module tb_rv_rf_wb_arb;
    import rv_pkg::*;
    typedef logic [103:0] obs_t;
    typedef struct {
        int     f, v0, rd0, v1, rd1;
        longint d0, d1;
        obs_t   exp;
    } vec_t;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int failures = 0;
    vec_t tbl [22];
    bit     mv [2];
    int     mrd [2];
    longint md [2];
    longint mt [2];
    int     mptr;
    always #5 clk = ~clk;
    rv_rf_wb_arb_if bus ();
    rv_rf_wb_arb dut (.clk(clk), .rstn(rstn), .bus(bus));

    function automatic obs_t mk_obs(input int en, input int wreg, input longint data, input int busy, input int r0, input int r1);
        return {1'(en), 5'(wreg), 64'(data), 32'(busy), 1'(r0), 1'(r1)};
    endfunction

    function automatic vec_t mk(input int f, input int v0, input int rd0, input longint d0, input int v1, input int rd1, input longint d1,
                                input int en, input int wreg, input longint wdata, input int busy, input int r0, input int r1);
        vec_t t;
        t.f = f; t.v0 = v0; t.rd0 = rd0; t.d0 = d0; t.v1 = v1; t.rd1 = rd1; t.d1 = d1;
        t.exp = mk_obs(en, wreg, wdata, busy, r0, r1);
        return t;
    endfunction

    task automatic drive(input int f, input int v0, input int rd0, input longint d0, input int v1, input int rd1, input longint d1);
        bus.flush_i    = 1'(f);
        bus.s0_valid_i = 1'(v0);
        bus.s0_rd_i    = 5'(rd0);
        bus.s0_data_i  = 64'(d0);
        bus.s1_valid_i = 1'(v1);
        bus.s1_rd_i    = 5'(rd1);
        bus.s1_data_i  = 64'(d1);
    endtask

    task automatic check(input string name, input obs_t exp);
        obs_t got;
        got = {bus.wr_en_o, bus.wr_reg_o, bus.wr_data_o, bus.busy_o, bus.s0_ready_o, bus.s1_ready_o};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h (en,reg,data,busy,rdy0,rdy1)", name, got, exp);
        end
    endtask

    initial begin
        tbl[0]  = mk(0, 1, 3, 'h33, 1, 4, 'h44,  0, 0, 0, 0, 1, 1);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0,        1, 3, 'h33, 'h18, 1, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0,        1, 4, 'h44, 'h10, 1, 1);
        tbl[3]  = mk(0, 1, 1, 'h11, 1, 2, 'h22,  0, 0, 0, 0, 1, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0,        1, 2, 'h22, 'h06, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0,        1, 1, 'h11, 'h02, 1, 1);
        tbl[6]  = mk(0, 1, 5, 'hA5, 0, 0, 0,     0, 0, 0, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0,        1, 5, 'hA5, 'h20, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 1);
        tbl[9]  = mk(0, 1, 0, 'hFF, 0, 0, 0,     0, 0, 0, 0, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 1);
        tbl[11] = mk(0, 1, 10, 'hA0, 1, 11, 'hB0, 0, 0, 0, 0, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0,        1, 10, 'hA0, 'hC00, 1, 0);
        tbl[13] = mk(0, 1, 7, 'h70, 1, 7, 'h71,  1, 11, 'hB0, 'h800, 1, 1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0,        1, 7, 'h70, 'h80, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0,        1, 7, 'h71, 'h80, 1, 1);
        tbl[16] = mk(0, 0, 0, 0, 1, 7, 'hC1,     0, 0, 0, 0, 1, 1);
        tbl[17] = mk(0, 1, 7, 'hC0, 0, 0, 0,     1, 7, 'hC1, 'h80, 1, 1);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0,        1, 7, 'hC0, 'h80, 1, 1);
        tbl[19] = mk(0, 1, 12, 'hD0, 1, 13, 'hD1, 0, 0, 0, 0, 1, 1);
        tbl[20] = mk(1, 1, 14, 'hE0, 0, 0, 0,    0, 0, 0, 'h3000, 0, 0);
        tbl[21] = mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 1);

        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("reset_state", mk_obs(0, 0, 0, 0, 1, 1));
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        foreach (tbl[i]) begin
            drive(tbl[i].f, tbl[i].v0, tbl[i].rd0, tbl[i].d0, tbl[i].v1, tbl[i].rd1, tbl[i].d1);
            #1 check($sformatf("vec%0d", i), tbl[i].exp);
            @(posedge clk);
            @(negedge clk);
        end

        // Fill both slots, then pull reset in the middle of the cycle.
        drive(0, 1, 20, 'h200, 1, 21, 'h210);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0);
        #1 check("both_full", mk_obs(1, 21, 'h210, 'h300000, 0, 1));
        #1 rstn = 1'b0;
        #1 check("async_reset", mk_obs(0, 0, 0, 0, 1, 1));
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 check($sformatf("post_reset%0d", k), mk_obs(0, 0, 0, 0, 1, 1));
            @(negedge clk);
        end

        // Random traffic against a timestamp-based model; the DUT has just been reset.
        mv = '{0, 0};
        mptr = 0;
        for (int c = 0; c < 3000; c++) begin
            int f, g, gi;
            int vi [2];
            int ri [2];
            longint di [2];
            bit rdy [2];
            bit both;
            bit [31:0] b;
            f = ($urandom_range(0, 15) == 0) ? 1 : 0;
            for (int n = 0; n < 2; n++) begin
                vi[n] = ($urandom_range(0, 3) != 0) ? 1 : 0;
                ri[n] = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 31));
                di[n] = {$urandom, $urandom};
            end
            drive(f, vi[0], ri[0], di[0], vi[1], ri[1], di[1]);
            both = mv[0] && mv[1];
            g = -1;
            if (f == 0) begin
                if (both) g = (mrd[0] == mrd[1]) ? (mt[0] < mt[1] ? 0 : 1) : mptr;
                else if (mv[0]) g = 0;
                else if (mv[1]) g = 1;
            end
            gi = (g < 0) ? 0 : g;
            b = '0;
            for (int n = 0; n < 2; n++) begin
                if (mv[n]) b[mrd[n]] = 1'b1;
                rdy[n] = (f == 0) && (!mv[n] || g == n);
            end
            b[0] = 1'b0;
            #1 check($sformatf("rand%0d", c), mk_obs(g >= 0, g >= 0 ? mrd[gi] : 0, g >= 0 ? md[gi] : 0, int'(b), rdy[0], rdy[1]));
            @(posedge clk);
            if (f != 0) mv = '{0, 0};
            else begin
                if (g >= 0) begin
                    mv[g] = 1'b0;
                    if (both) mptr = 1 - g;
                end
                for (int n = 0; n < 2; n++)
                    if (vi[n] != 0 && rdy[n] && ri[n] != 0) begin
                        mv[n] = 1'b1;
                        mrd[n] = ri[n];
                        md[n] = di[n];
                        mt[n] = 2 * longint'(c) + n;
                    end
            end
            @(negedge clk);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
